// File: rtl/ret_addr_stack_ctrl_pkg.sv
// Shared constants for the return-address stack controller: state encodings,
// default geometry and the operation-type flag values.
package ret_addr_stack_ctrl_pkg;

    localparam int RAS_DEPTH  = 8;
    localparam int RAS_ADDR_W = 16;
    localparam int RAS_CNT_W  = 4;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_PUSH  = 3'd1;
    localparam logic [2:0] ST_POP   = 3'd2;
    localparam logic [2:0] ST_ACK   = 3'd3;
    localparam logic [2:0] ST_ERROR = 3'd4;

    localparam logic OP_CALL = 1'b0;
    localparam logic OP_RET  = 1'b1;

endpackage

// File: rtl/ret_addr_stack_ctrl_if.sv
// Decoder-to-RAS bundle: CALL/RET request handshake, popped address, stack
// FSM strobes and the sticky status flags.
interface ret_addr_stack_ctrl_if
    import ret_addr_stack_ctrl_pkg::*;
#(
    parameter int ADDR_W = RAS_ADDR_W,
    parameter int CNT_W  = RAS_CNT_W
);

    logic              CallReq;
    logic              RetReq;
    logic [ADDR_W-1:0] CallAddr;
    logic              Ack;
    logic              RetValid;
    logic [ADDR_W-1:0] RetAddr;
    logic              PushEnbl;
    logic              PopEnbl;
    logic [CNT_W-1:0]  Depth;
    logic              Overflow;
    logic              Underflow;
    logic              Error;

    modport master (
        output CallReq, RetReq, CallAddr,
        input  Ack, RetValid, RetAddr, PushEnbl, PopEnbl,
        input  Depth, Overflow, Underflow, Error
    );

    modport slave (
        input  CallReq, RetReq, CallAddr,
        output Ack, RetValid, RetAddr, PushEnbl, PopEnbl,
        output Depth, Overflow, Underflow, Error
    );

endinterface

// File: rtl/ret_addr_stack_ctrl_ras_storage.sv
// Return-address register file: one synchronous write port and one registered
// read port. Contents are deliberately not reset.
module ras_storage
#(
    parameter  int DEPTH  = 8,
    parameter  int ADDR_W = 16,
    localparam int IDX_W  = $clog2(DEPTH)
)
(
    input  logic              clk,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [ADDR_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [ADDR_W-1:0] rd_data
);

    logic [ADDR_W-1:0] mem_r [DEPTH];
    logic [ADDR_W-1:0] rd_data_r;

    // Write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_idx] <= wr_data;
        end
    end

    // Registered read port; holds its last value when not enabled.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data_r <= mem_r[rd_idx];
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/ret_addr_stack_ctrl.sv
// Return-address stack sequencer: accepts CALL/RET requests, owns the LIFO
// storage, drives the stack FSM strobes and latches overflow/underflow traps.
module ret_addr_stack_ctrl
    import ret_addr_stack_ctrl_pkg::*;
#(
    parameter int DEPTH  = RAS_DEPTH,
    parameter int ADDR_W = RAS_ADDR_W,
    parameter int CNT_W  = RAS_CNT_W
)
(
    input logic                 Clk,
    input logic                 Reset,
    ret_addr_stack_ctrl_if.slave bus
);

    localparam int               IDX_W   = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ZERO_C  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    logic [2:0]        state_r;
    logic [2:0]        state_next_s;
    logic [CNT_W-1:0]  depth_r;
    logic              op_type_r;
    logic              op_type_s;
    logic              ovf_set_s;
    logic              unf_set_s;
    logic              ack_r;
    logic              ret_valid_r;
    logic              push_r;
    logic              pop_r;
    logic              ovf_r;
    logic              unf_r;
    logic              err_r;
    logic [ADDR_W-1:0] ret_addr_r;

    logic              rd_en_s;
    logic [IDX_W-1:0]  rd_idx_s;
    logic [IDX_W-1:0]  wr_idx_s;
    logic [ADDR_W-1:0] rd_data_s;

    // Next-state decode; overflow is caught here so the write index never wraps.
    always_comb begin
        state_next_s = state_r;
        ovf_set_s    = 1'b0;
        unf_set_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.CallReq && bus.RetReq) begin
                    state_next_s = ST_ERROR;
                end else if (bus.CallReq && (depth_r == DEPTH_C)) begin
                    state_next_s = ST_ERROR;
                    ovf_set_s    = 1'b1;
                end else if (bus.CallReq) begin
                    state_next_s = ST_PUSH;
                end else if (bus.RetReq && (depth_r == ZERO_C)) begin
                    state_next_s = ST_ERROR;
                    unf_set_s    = 1'b1;
                end else if (bus.RetReq) begin
                    state_next_s = ST_POP;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_PUSH:  state_next_s = ST_ACK;
            ST_POP:   state_next_s = ST_ACK;
            ST_ACK:   state_next_s = ST_IDLE;
            ST_ERROR: state_next_s = ST_ERROR;
            default:  state_next_s = ST_ERROR;
        endcase
    end

    // Type of the operation that will be acknowledged next.
    always_comb begin
        op_type_s = op_type_r;
        if (state_r == ST_PUSH) begin
            op_type_s = OP_CALL;
        end else if (state_r == ST_POP) begin
            op_type_s = OP_RET;
        end else begin
            op_type_s = op_type_r;
        end
    end

    // The storage read is launched in IDLE so its registered data is ready
    // during POP and captured into RetAddr at the end of that cycle.
    assign rd_en_s  = (state_r == ST_IDLE) && (state_next_s == ST_POP);
    assign rd_idx_s = depth_r[IDX_W-1:0] - IDX_W'(1);
    assign wr_idx_s = depth_r[IDX_W-1:0];

    ras_storage #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_storage (
        .clk     (Clk),
        .wr_en   (state_r == ST_PUSH),
        .wr_idx  (wr_idx_s),
        .wr_data (bus.CallAddr),
        .rd_en   (rd_en_s),
        .rd_idx  (rd_idx_s),
        .rd_data (rd_data_s)
    );

    // Control state, depth counter, registered outputs and sticky flags.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r     <= ST_IDLE;
            depth_r     <= ZERO_C;
            op_type_r   <= OP_CALL;
            ack_r       <= 1'b0;
            ret_valid_r <= 1'b0;
            push_r      <= 1'b0;
            pop_r       <= 1'b0;
            ovf_r       <= 1'b0;
            unf_r       <= 1'b0;
            err_r       <= 1'b0;
            ret_addr_r  <= {ADDR_W{1'b0}};
        end else begin
            state_r     <= state_next_s;
            op_type_r   <= op_type_s;
            push_r      <= (state_next_s == ST_PUSH);
            pop_r       <= (state_next_s == ST_POP);
            ack_r       <= (state_next_s == ST_ACK);
            ret_valid_r <= (state_next_s == ST_ACK) && (op_type_s == OP_RET);
            ovf_r       <= ovf_r | ovf_set_s;
            unf_r       <= unf_r | unf_set_s;
            err_r       <= err_r | (state_next_s == ST_ERROR);
            if (state_r == ST_PUSH) begin
                depth_r <= depth_r + ONE_C;
            end else if (state_r == ST_POP) begin
                depth_r    <= depth_r - ONE_C;
                ret_addr_r <= rd_data_s;
            end else begin
                depth_r <= depth_r;
            end
        end
    end

    assign bus.Ack       = ack_r;
    assign bus.RetValid  = ret_valid_r;
    assign bus.RetAddr   = ret_addr_r;
    assign bus.PushEnbl  = push_r;
    assign bus.PopEnbl   = pop_r;
    assign bus.Depth     = depth_r;
    assign bus.Overflow  = ovf_r;
    assign bus.Underflow = unf_r;
    assign bus.Error     = err_r;

endmodule

// File: tb/tb_ret_addr_stack_ctrl.sv
// Self-checking bench for ret_addr_stack_ctrl: vector table, hand-written
// corner sequences and randomized traffic against a queue-based stack model.
module tb_ret_addr_stack_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    ret_addr_stack_ctrl_if #(.ADDR_W(16), .CNT_W(4)) bus ();

    ret_addr_stack_ctrl #(.DEPTH(8), .ADDR_W(16), .CNT_W(4)) dut (
        .Clk   (clk),
        .Reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  ack_cyc;
        logic [3:0]  pushes;
        logic [3:0]  pops;
        logic        both;
        logic        extra_ack;
        logic        rv;
        logic [15:0] raddr;
    } obs_t;

    typedef struct packed {
        logic        call;
        logic        ret;
        logic [15:0] addr;
        logic        exp_ack;
        logic        exp_rv;
        logic [15:0] exp_raddr;
        logic [3:0]  exp_push;
        logic [3:0]  exp_pop;
        logic [3:0]  exp_depth;
        logic        exp_ovf;
        logic        exp_unf;
        logic        exp_err;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Leaves the caller #1 after a rising edge with reset released.
    task automatic do_reset();
        reset        = 1'b1;
        bus.CallReq  = 1'b0;
        bus.RetReq   = 1'b0;
        bus.CallAddr = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Holds one request until Ack (or a 5-cycle bound), then one settling cycle.
    task automatic run_op(input logic call, input logic ret, input logic [15:0] addr, output obs_t o);
        o = '0;
        bus.CallReq  = call;
        bus.RetReq   = ret;
        bus.CallAddr = addr;
        for (int k = 1; k <= 5; k++) begin
            if (o.ack_cyc == 4'd0) begin
                @(posedge clk);
                #1;
                if (bus.PushEnbl) o.pushes = o.pushes + 4'd1;
                if (bus.PopEnbl)  o.pops   = o.pops + 4'd1;
                if (bus.PushEnbl && bus.PopEnbl) o.both = 1'b1;
                if (bus.Ack) begin
                    o.ack_cyc = 4'(k);
                    o.rv      = bus.RetValid;
                    o.raddr   = bus.RetAddr;
                end
            end
        end
        bus.CallReq = 1'b0;
        bus.RetReq  = 1'b0;
        @(posedge clk);
        #1;
        if (bus.PushEnbl) o.pushes = o.pushes + 4'd1;
        if (bus.PopEnbl)  o.pops   = o.pops + 4'd1;
        if (bus.Ack)      o.extra_ack = 1'b1;
    endtask

    task automatic chk_flags(input string tag, input logic ovf, input logic unf, input logic err);
        chk({tag, ".ovf"}, 32'(bus.Overflow), 32'(ovf));
        chk({tag, ".unf"}, 32'(bus.Underflow), 32'(unf));
        chk({tag, ".err"}, 32'(bus.Error), 32'(err));
    endtask

    initial begin
        obs_t        o;
        logic [15:0] model_q [$];
        logic [15:0] exp_addr;
        logic [15:0] a;
        logic        do_call;

        checks = 0;
        errors = 0;
        reset  = 1'b1;

        //            call  ret   addr      ack   rv    raddr     push  pop   depth ovf   unf   err
        vecs[0] = '{1'b1, 1'b0, 16'h1234, 1'b1, 1'b0, 16'h0000, 4'd1, 4'd0, 4'd1, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 16'h1234, 4'd0, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 16'h0100, 1'b1, 1'b0, 16'h0000, 4'd1, 4'd0, 4'd1, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 16'h0200, 1'b1, 1'b0, 16'h0000, 4'd1, 4'd0, 4'd2, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 16'h0300, 1'b1, 1'b0, 16'h0000, 4'd1, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 16'h0300, 4'd0, 4'd1, 4'd2, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 16'h0200, 4'd0, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 16'h0100, 4'd0, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1};

        do_reset();
        chk("rst.ack", 32'(bus.Ack), 32'd0);
        chk("rst.rv", 32'(bus.RetValid), 32'd0);
        chk("rst.push", 32'(bus.PushEnbl), 32'd0);
        chk("rst.pop", 32'(bus.PopEnbl), 32'd0);
        chk("rst.depth", 32'(bus.Depth), 32'd0);
        chk("rst.raddr", 32'(bus.RetAddr), 32'd0);
        chk_flags("rst", 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].call, vecs[i].ret, vecs[i].addr, o);
            chk($sformatf("vec%0d.ack_cyc", i), 32'(o.ack_cyc), vecs[i].exp_ack ? 32'd2 : 32'd0);
            if (vecs[i].exp_ack) begin
                chk($sformatf("vec%0d.rv", i), 32'(o.rv), 32'(vecs[i].exp_rv));
            end
            if (vecs[i].exp_rv) begin
                chk($sformatf("vec%0d.raddr", i), 32'(o.raddr), 32'(vecs[i].exp_raddr));
            end
            chk($sformatf("vec%0d.push", i), 32'(o.pushes), 32'(vecs[i].exp_push));
            chk($sformatf("vec%0d.pop", i), 32'(o.pops), 32'(vecs[i].exp_pop));
            chk($sformatf("vec%0d.extra_ack", i), 32'(o.extra_ack), 32'd0);
            chk($sformatf("vec%0d.depth", i), 32'(bus.Depth), 32'(vecs[i].exp_depth));
            chk_flags($sformatf("vec%0d", i), vecs[i].exp_ovf, vecs[i].exp_unf, vecs[i].exp_err);
        end

        // Fill to capacity, then one CALL too many.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            run_op(1'b1, 1'b0, 16'(16'hA000 + i), o);
            chk($sformatf("fill%0d.ack_cyc", i), 32'(o.ack_cyc), 32'd2);
            chk($sformatf("fill%0d.depth", i), 32'(bus.Depth), 32'(i + 1));
        end
        run_op(1'b1, 1'b0, 16'hDEAD, o);
        chk("ovf.ack_cyc", 32'(o.ack_cyc), 32'd0);
        chk("ovf.push", 32'(o.pushes), 32'd0);
        chk("ovf.depth", 32'(bus.Depth), 32'd8);
        chk_flags("ovf", 1'b1, 1'b0, 1'b1);

        // Simultaneous requests, then a CALL that must be ignored.
        do_reset();
        run_op(1'b1, 1'b1, 16'h5555, o);
        chk("both.ack_cyc", 32'(o.ack_cyc), 32'd0);
        chk("both.strobes", 32'(o.pushes + o.pops), 32'd0);
        chk_flags("both", 1'b0, 1'b0, 1'b1);
        run_op(1'b1, 1'b0, 16'h6666, o);
        chk("both_after.ack_cyc", 32'(o.ack_cyc), 32'd0);
        chk("both_after.push", 32'(o.pushes), 32'd0);
        chk("both_after.depth", 32'(bus.Depth), 32'd0);

        // Reset landing in the PUSH cycle of a CALL at Depth 3.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            run_op(1'b1, 1'b0, 16'(16'h0B00 + i), o);
        end
        chk("midrst.pre_depth", 32'(bus.Depth), 32'd3);
        bus.CallReq  = 1'b1;
        bus.CallAddr = 16'h0BBB;
        @(posedge clk);
        #1;
        chk("midrst.push", 32'(bus.PushEnbl), 32'd1);
        reset       = 1'b1;
        bus.CallReq = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("midrst.ack", 32'(bus.Ack), 32'd0);
        chk("midrst.push_after", 32'(bus.PushEnbl), 32'd0);
        chk("midrst.depth", 32'(bus.Depth), 32'd0);
        chk_flags("midrst", 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("midrst.ack_next", 32'(bus.Ack), 32'd0);
        chk("midrst.strobe_next", 32'(bus.PushEnbl | bus.PopEnbl), 32'd0);
        run_op(1'b1, 1'b0, 16'h0C0C, o);
        chk("midrst.resume_ack", 32'(o.ack_cyc), 32'd2);
        chk("midrst.resume_depth", 32'(bus.Depth), 32'd1);

        // Random CALL/RET traffic against a LIFO model.
        do_reset();
        model_q.delete();
        for (int n = 0; n < 150; n++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            if (model_q.size() == 0) begin
                do_call = 1'b1;
            end else if (model_q.size() == 8) begin
                do_call = 1'b0;
            end else begin
                do_call = ($urandom_range(0, 1) == 0);
            end
            a = 16'($urandom);
            run_op(do_call, !do_call, a, o);
            if (do_call) begin
                model_q.push_back(a);
                exp_addr = 16'h0000;
            end else begin
                exp_addr = model_q.pop_back();
            end
            chk($sformatf("rnd%0d.ack_cyc", n), 32'(o.ack_cyc), 32'd2);
            chk($sformatf("rnd%0d.rv", n), 32'(o.rv), 32'(!do_call));
            if (!do_call) begin
                chk($sformatf("rnd%0d.raddr", n), 32'(o.raddr), 32'(exp_addr));
            end
            chk($sformatf("rnd%0d.push", n), 32'(o.pushes), do_call ? 32'd1 : 32'd0);
            chk($sformatf("rnd%0d.pop", n), 32'(o.pops), do_call ? 32'd0 : 32'd1);
            chk($sformatf("rnd%0d.both", n), 32'(o.both), 32'd0);
            chk($sformatf("rnd%0d.depth", n), 32'(bus.Depth), 32'(model_q.size()));
        end
        chk_flags("rnd_end", 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ret_addr_stack_ctrl.md
Name: ret_addr_stack_ctrl

Overview:
- Requester-side sequencer and storage for the core's hardware return-address stack.
- Accepts CALL/RET requests from the instruction decoder over a req/ack handshake.
- Writes and reads the LIFO storage it owns, and emits single-cycle PushEnbl/PopEnbl pulses that drive the stack pointer/status FSM, keeping both in lock-step.
- Overflow and underflow are detected locally and latched for the trap logic.

Parameters:
- DEPTH, 8, number of return-address entries (matches the 3-bit stack address space).
- ADDR_W, 16, return-address width in bits.
- CNT_W, 4, depth counter width; must be at least clog2(DEPTH+1).

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- CallReq  in  1  level request to push CallAddr; held until Ack.
- RetReq  in  1  level request to pop; held until Ack.
- CallAddr  in  ADDR_W  return address to push; stable while CallReq is high.
- Ack  out  1  one-cycle completion pulse for the current request.
- RetValid  out  1  high with Ack when a RET completes.
- RetAddr  out  ADDR_W  popped address; valid while RetValid is high, holds its value otherwise.
- PushEnbl  out  1  one-cycle push strobe to the stack FSM.
- PopEnbl  out  1  one-cycle pop strobe to the stack FSM.
- Depth  out  CNT_W  number of valid entries, 0..DEPTH.
- Overflow  out  1  sticky; a CALL was issued with Depth==DEPTH.
- Underflow  out  1  sticky; a RET was issued with Depth==0.
- Error  out  1  sticky; set in the ERROR state for any cause, including simultaneous requests.

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high.
- Reset values: state=IDLE; Depth=0; Ack, RetValid, PushEnbl, PopEnbl, Overflow, Underflow and Error all 0; RetAddr=0. Storage is not cleared.
- States are IDLE, PUSH, POP, ACK and ERROR. All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.
- IDLE, evaluated at each edge, in priority order:
  - CallReq & RetReq -> ERROR, Error=1, no stack effect.
  - CallReq & Depth==DEPTH -> ERROR, Overflow=1.
  - CallReq -> PUSH.
  - RetReq & Depth==0 -> ERROR, Underflow=1.
  - RetReq -> POP.
  - Otherwise stay in IDLE.
- PUSH (one cycle): PushEnbl=1. At the end of the cycle, mem[Depth] <= CallAddr and Depth <= Depth+1. Next state ACK.
- POP (one cycle): PopEnbl=1. At the end of the cycle, RetAddr <= mem[Depth-1], Depth <= Depth-1, and the type flag is set to RET. Next state ACK.
- ACK (one cycle): Ack=1. RetValid=1 only if the completed operation was a RET. Requests are ignored in this cycle. Next state IDLE.
- Latency: request seen in IDLE at edge n -> PUSH/POP during cycle n+1 -> Ack during cycle n+2. Throughput is one operation per 3 cycles.
- Handshake rule: the requester deasserts its request in the cycle after Ack. A request still high in IDLE is treated as a new request.
- ERROR is terminal until Reset:
  - Ack, PushEnbl and PopEnbl stay 0, and Depth is frozen.
  - Overflow, Underflow and Error hold.
  - Trap logic observes these flags; requests are never acknowledged.
- Strobe discipline: PushEnbl and PopEnbl are never high in the same cycle. Each completed operation produces exactly one strobe, so the stack FSM's TOS equals Depth whenever Depth is below DEPTH.
- Wrap-around: none. Depth saturates logically because overflow is caught before the write. Storage index is Depth for push and Depth-1 for pop, always in range.
- Reset mid-operation: a Reset during PUSH or POP aborts the operation. The state returns to IDLE with Depth=0, and no Ack or strobe is issued in the following cycle.

Decomposition:
- Shared package: state encodings (IDLE, PUSH, POP, ACK, ERROR as 3-bit constants), the DEPTH and ADDR_W defaults, and the op-type flag constants CALL/RET.
- One natural sub-module, ras_storage: a DEPTH x ADDR_W register file with one synchronous write port and one registered read port. It has no reset.

Test Plan:
- Reset, then CallReq with CallAddr=16'h1234 -> PushEnbl in cycle 1, Ack in cycle 2, RetValid=0, Depth=1.
- Push 16'h0100, 16'h0200, 16'h0300, then three RETs -> RetAddr returns 16'h0300, 16'h0200, 16'h0100 with RetValid=1 on each Ack; final Depth=0; exactly one PopEnbl per RET.
- Eight CALLs followed by a ninth -> Depth=8 after eight; the ninth gives Overflow=1 and Error=1, with no PushEnbl, no Ack, and Depth stays 8.
- RetReq immediately after reset -> Underflow=1, Error=1, no PopEnbl, no Ack.
- CallReq and RetReq asserted in the same IDLE cycle -> ERROR, Error=1, Overflow=0, Underflow=0, no strobes; a following CallReq is ignored.
- Reset asserted during the PUSH cycle of a CALL with Depth=3 -> next cycle is IDLE with Depth=0, Ack=0, and all flags cleared.
